turn_sequencer: RTL and testbench
=================================

TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000_000, meaning cycles allowed per turn before forfeit; used only when TURN_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetN  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port moveReq  input  1  one-cycle debounced place-mark pulse from the cursor controller.
REQ-005 SHALL have port cursor  input  9  one-hot cell select; bit index = row*3+col, bit 0 top-left.
REQ-006 SHALL have port newGame  input  1  one-cycle pulse requesting a board clear and restart.
REQ-007 SHALL have port boardX, boardO  input  9 each  current board contents read back from the game model.
REQ-008 SHALL have port writeEn  output  1  one-cycle write strobe to the game model.
REQ-009 SHALL have port writeMask  output  9  one-hot cell to write; valid while writeEn=1, else 0.
REQ-010 SHALL have port writePlayer  output  1  0 = X, 1 = O; valid while writeEn=1.
REQ-011 SHALL have port clearBoard  output  1  one-cycle strobe clearing both board planes.
REQ-012 SHALL have port turn  output  1  player to move, 0 = X, 1 = O.
REQ-013 SHALL have port winner  output  2  00 none, 01 X, 10 O, 11 draw.
REQ-014 SHALL have port winLine  output  8  completed lines: [2:0] rows 0-2, [5:3] cols 0-2, [6] cells 0/4/8, [7] cells 2/4/6.
REQ-015 SHALL have port reject  output  1  one-cycle pulse when a move is refused.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, WRITE, SETTLE, EVAL, OVER, CLEAR; all outputs registered or decoded from the state register (Moore).
REQ-017 IDLE: on moveReq, latch cursor and go to CHECK; moveReq in any other state is dropped, not queued.
REQ-018 CHECK: latched cursor not one-hot (zero or more than one bit), or overlapping boardX|boardO -> reject=1 for one cycle, back to IDLE; else go to WRITE.
REQ-019 WRITE: writeEn=1, writeMask=latched cursor, writePlayer=turn for exactly one cycle; moveCount increments; go to SETTLE.
REQ-020 SETTLE: one idle cycle for the game model to update; then EVAL.
REQ-021 EVAL: compute all 8 lines on boardX and boardO; any X line -> winner=01; else any O line -> winner=10; else moveCount=9 -> winner=11; the first two update winLine and go to OVER; otherwise toggle turn and return to IDLE.
REQ-022 moveReq-to-writeEn latency SHALL be 2 cycles; moveReq-to-updated turn SHALL be 5 cycles.
REQ-023 moveCount SHALL be 4 bits, range 0-9, never wrapping; the draw check uses moveCount=9.
REQ-024 OVER: holds winner and winLine; ignores moveReq with no reject.
REQ-025 newGame in any state SHALL have priority over all other events and move the FSM to CLEAR on the next edge; a writeEn already asserted in that cycle still completes.
REQ-026 CLEAR: clearBoard=1 for one cycle; moveCount=0, winner=00, winLine=0, turn=0; go to IDLE.

Reset
REQ-027 resetN low SHALL asynchronously force state=IDLE, turn=0, moveCount=0, winner=00, winLine=0, writeEn=0, writeMask=0, writePlayer=0, clearBoard=0, reject=0, and the timeout counter to 0.
REQ-028 Reset SHALL NOT pulse clearBoard; the game model is reset separately.

Configuration
REQ-029 With TURN_TIMEOUT_EN defined, a counter SHALL count cycles in IDLE, clearing on every turn change and on CLEAR.
REQ-030 With TURN_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 in IDLE SHALL toggle turn without a write (the player forfeits the move) and clear the counter.
REQ-031 Without TURN_TIMEOUT_EN, no counter logic SHALL exist and IDLE waits indefinitely.

Structure
REQ-032 A shared package SHALL hold the state encoding, the winner codes (NONE/XWIN/OWIN/DRAW), and the eight 9-bit line masks.
REQ-033 Line detection SHALL be a combinational sub-module line_check (9-bit plane in, 8-bit winLine out), instantiated once per plane.

Verification
REQ-034 Reset, moveReq with cursor=9'h001 -> writeEn at cycle+2 with writeMask=9'h001, writePlayer=0; turn=1 five cycles after moveReq.
REQ-035 boardO=9'h001 and a move to cursor=9'h001 -> reject pulses once, no writeEn, turn unchanged.
REQ-036 cursor=9'h003 or 9'h000 -> reject, no write.
REQ-037 X fills cells 0,1,2 over alternating turns -> winner=01, winLine=8'h01; further moveReq ignored; newGame -> clearBoard one cycle, winner=00, turn=0.
REQ-038 Nine legal moves with no line -> winner=11 after the ninth EVAL; newGame asserted during WRITE -> CLEAR follows immediately.
REQ-039 TURN_TIMEOUT_EN defined with TIMEOUT_CYCLES=16, no moveReq -> turn toggles after 16 IDLE cycles, no writeEn.

Source files
------------

// File: rtl/turn_sequencer_pkg.sv
// Shared definitions for the tic-tac-toe turn sequencer: FSM state
// encoding, winner codes, the eight winning-line masks and a one-hot helper.
package turn_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_EVAL   = 3'd4,
        ST_OVER   = 3'd5,
        ST_CLEAR  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        XWIN = 2'b01,
        OWIN = 2'b10,
        DRAW = 2'b11
    } winner_t;

    // Cell index = row*3+col; entry order matches the winLine bit order:
    // rows 0-2, columns 0-2, main diagonal, anti-diagonal.
    localparam logic [8:0] LINE_MASKS [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    localparam logic [3:0] MAX_MOVES = 4'd9;

    function automatic logic isOneHot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

endpackage

// File: rtl/turn_sequencer_line_check.sv
// Combinational detector of completed lines on one board plane.
module line_check
    import turn_sequencer_pkg::*;
(
    input  logic [8:0] i_plane,
    output logic [7:0] o_lines
);

    // A line is complete when every cell of its mask is occupied.
    always_comb begin
        o_lines = '0;
        for (int i = 0; i < 8; i++) begin
            o_lines[i] = ((i_plane & LINE_MASKS[i]) == LINE_MASKS[i]);
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer for a tic-tac-toe game model: validates moves, issues
// write strobes, evaluates wins/draws and handles new-game requests.
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES idle cycles.
module turn_sequencer
    import turn_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000_000
)
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       moveReq,
    input  logic [8:0] cursor,
    input  logic       newGame,
    input  logic [8:0] boardX,
    input  logic [8:0] boardO,
    output logic       writeEn,
    output logic [8:0] writeMask,
    output logic       writePlayer,
    output logic       clearBoard,
    output logic       turn,
    output logic [1:0] winner,
    output logic [7:0] winLine,
    output logic       reject
);

    if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t     r_state;
    state_t     w_nextState;
    logic [8:0] r_cursor;
    logic [3:0] r_moveCount;
    logic       r_turn;
    winner_t    r_winner;
    logic [7:0] r_winLine;
    logic       r_reject;

    logic [7:0] w_linesX;
    logic [7:0] w_linesO;
    logic       w_cursorBad;
    logic       w_winX;
    logic       w_winO;
    logic       w_draw;
    logic       w_timeout;

    line_check u_lineX (.i_plane(boardX), .o_lines(w_linesX));
    line_check u_lineO (.i_plane(boardO), .o_lines(w_linesO));

    assign w_cursorBad = !isOneHot(r_cursor) || ((r_cursor & (boardX | boardO)) != 9'd0);
    assign w_winX      = |w_linesX;
    assign w_winO      = |w_linesO;
    assign w_draw      = (r_moveCount == MAX_MOVES);

`ifdef TURN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_idleCount;
    logic             w_evalToggle;

    assign w_evalToggle = (r_state == ST_EVAL) && !w_winX && !w_winO && !w_draw;
    assign w_timeout    = (r_state == ST_IDLE) && !moveReq && !newGame &&
                          (r_idleCount >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter; restarts whenever the turn changes or the game clears.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_idleCount <= '0;
        end else if (newGame || (r_state == ST_CLEAR) || w_timeout || w_evalToggle) begin
            r_idleCount <= '0;
        end else if (r_state == ST_IDLE) begin
            r_idleCount <= r_idleCount + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic with newGame overriding everything, plus Moore strobes.
    always_comb begin
        w_nextState = r_state;
        writeEn     = 1'b0;
        writeMask   = 9'd0;
        writePlayer = 1'b0;
        clearBoard  = 1'b0;

        if (newGame) begin
            w_nextState = ST_CLEAR;
        end else begin
            case (r_state)
                ST_IDLE:   if (moveReq) w_nextState = ST_CHECK;
                ST_CHECK:  w_nextState = w_cursorBad ? ST_IDLE : ST_WRITE;
                ST_WRITE:  w_nextState = ST_SETTLE;
                ST_SETTLE: w_nextState = ST_EVAL;
                ST_EVAL:   w_nextState = (w_winX || w_winO || w_draw) ? ST_OVER : ST_IDLE;
                ST_OVER:   w_nextState = ST_OVER;
                ST_CLEAR:  w_nextState = ST_IDLE;
                default:   w_nextState = ST_IDLE;
            endcase
        end

        if (r_state == ST_WRITE) begin
            writeEn     = 1'b1;
            writeMask   = r_cursor;
            writePlayer = r_turn;
        end
        clearBoard = (r_state == ST_CLEAR);
    end

    // Game bookkeeping: cursor latch, move count, turn, result and reject pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cursor    <= 9'd0;
            r_moveCount <= 4'd0;
            r_turn      <= 1'b0;
            r_winner    <= NONE;
            r_winLine   <= 8'd0;
            r_reject    <= 1'b0;
        end else begin
            r_reject <= 1'b0;
            if ((r_state == ST_IDLE) && moveReq && !newGame) begin
                r_cursor <= cursor;
            end
            if ((r_state == ST_WRITE) && (r_moveCount < MAX_MOVES)) begin
                r_moveCount <= r_moveCount + 4'd1;
            end
            if (r_state == ST_CLEAR) begin
                r_moveCount <= 4'd0;
                r_winner    <= NONE;
                r_winLine   <= 8'd0;
                r_turn      <= 1'b0;
            end else if (!newGame) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_timeout) r_turn <= ~r_turn;
                    end
                    ST_CHECK: begin
                        r_reject <= w_cursorBad;
                    end
                    ST_EVAL: begin
                        if (w_winX) begin
                            r_winner  <= XWIN;
                            r_winLine <= w_linesX;
                        end else if (w_winO) begin
                            r_winner  <= OWIN;
                            r_winLine <= w_linesO;
                        end else if (w_draw) begin
                            r_winner  <= DRAW;
                        end else begin
                            r_turn    <= ~r_turn;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign turn    = r_turn;
    assign winner  = r_winner;
    assign winLine = r_winLine;
    assign reject  = r_reject;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed scenarios plus random
// games, compared against a cell-array reference of the game rules.
`timescale 1ns/1ps
module tb_turn_sequencer;

    localparam int TO_CYCLES = 16;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       moveReq = 1'b0;
    logic [8:0] cursor = 9'd0;
    logic       newGame = 1'b0;
    logic [8:0] boardX;
    logic [8:0] boardO;
    logic       writeEn;
    logic [8:0] writeMask;
    logic       writePlayer;
    logic       clearBoard;
    logic       turn;
    logic [1:0] winner;
    logic [7:0] winLine;
    logic       reject;

    logic [8:0] gmX = 9'd0;
    logic [8:0] gmO = 9'd0;
    logic [8:0] preloadO = 9'd0;

    int checks = 0;
    int errors = 0;

    int         refCell [9];
    logic       refTurn;
    logic [1:0] refWinner;
    logic [7:0] refLine;
    int         refMoves;

    turn_sequencer #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .moveReq    (moveReq),
        .cursor     (cursor),
        .newGame    (newGame),
        .boardX     (boardX),
        .boardO     (boardO),
        .writeEn    (writeEn),
        .writeMask  (writeMask),
        .writePlayer(writePlayer),
        .clearBoard (clearBoard),
        .turn       (turn),
        .winner     (winner),
        .winLine    (winLine),
        .reject     (reject)
    );

    always #5 clk = ~clk;

    // Game model: stores written marks, wiped by clearBoard.
    always @(posedge clk) begin
        if (clearBoard) begin
            gmX <= 9'd0;
            gmO <= 9'd0;
        end else if (writeEn) begin
            if (writePlayer) gmO <= gmO | writeMask;
            else             gmX <= gmX | writeMask;
        end
    end

    assign boardX = gmX;
    assign boardO = gmO | preloadO;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] linesOf(input int who);
        logic [7:0] l;
        l = 8'd0;
        for (int k = 0; k < 3; k++) begin
            l[k]   = (refCell[3*k] == who) && (refCell[3*k+1] == who) && (refCell[3*k+2] == who);
            l[3+k] = (refCell[k] == who) && (refCell[k+3] == who) && (refCell[k+6] == who);
        end
        l[6] = (refCell[0] == who) && (refCell[4] == who) && (refCell[8] == who);
        l[7] = (refCell[2] == who) && (refCell[4] == who) && (refCell[6] == who);
        return l;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 9; i++) refCell[i] = 0;
        refTurn   = 1'b0;
        refWinner = 2'b00;
        refLine   = 8'd0;
        refMoves  = 0;
    endtask

    // One move request; checks write/reject timing and the result five cycles later.
    task automatic applyStimulus(input logic [8:0] c, input string tag);
        int   idx;
        bit   over;
        bit   legal;
        bit   expWrite;
        int   wrCount;
        int   rejCount;
        logic wrAt2;
        logic [8:0] maskAt2;
        logic plyAt2;
        logic [7:0] lx;
        logic [7:0] lo;

        idx = 0;
        for (int i = 0; i < 9; i++) if (c[i]) idx = i;
        over     = (refWinner != 2'b00);
        legal    = ($countones(c) == 1) && (refCell[idx] == 0);
        expWrite = legal && !over;

        cursor  = c;
        moveReq = 1'b1;
        @(posedge clk); #1;
        moveReq = 1'b0;
        cursor  = 9'($urandom);

        wrCount  = 0;
        rejCount = 0;
        wrAt2    = 1'b0;
        maskAt2  = 9'd0;
        plyAt2   = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            if (writeEn === 1'b1) wrCount++;
            if (reject === 1'b1) rejCount++;
            if (cyc == 2) begin
                wrAt2   = writeEn;
                maskAt2 = writeMask;
                plyAt2  = writePlayer;
            end
        end

        checkOutput({tag, "_writeAt2"}, wrAt2, expWrite);
        checkOutput({tag, "_writeCount"}, wrCount, expWrite ? 1 : 0);
        checkOutput({tag, "_rejectCount"}, rejCount, (!legal && !over) ? 1 : 0);
        if (expWrite) begin
            checkOutput({tag, "_mask"}, maskAt2, c);
            checkOutput({tag, "_player"}, plyAt2, refTurn);
            refCell[idx] = refTurn ? 2 : 1;
            refMoves++;
            lx = linesOf(1);
            lo = linesOf(2);
            if (lx != 8'd0) begin
                refWinner = 2'b01;
                refLine   = lx;
            end else if (lo != 8'd0) begin
                refWinner = 2'b10;
                refLine   = lo;
            end else if (refMoves == 9) begin
                refWinner = 2'b11;
            end else begin
                refTurn = ~refTurn;
            end
        end
        checkOutput({tag, "_turn"}, turn, refTurn);
        checkOutput({tag, "_winner"}, winner, refWinner);
        checkOutput({tag, "_winLine"}, winLine, refLine);
    endtask

    task automatic doNewGame(input string tag);
        newGame = 1'b1;
        @(posedge clk); #1;
        newGame = 1'b0;
        checkOutput({tag, "_clearOn"}, clearBoard, 1'b1);
        @(posedge clk); #1;
        checkOutput({tag, "_clearOff"}, clearBoard, 1'b0);
        checkOutput({tag, "_winner"}, winner, 2'b00);
        checkOutput({tag, "_turn"}, turn, 1'b0);
        checkOutput({tag, "_winLine"}, winLine, 8'd0);
        resetModel();
    endtask

    initial begin
        logic [8:0] drawSeq [9];
        int         wrSeen;
        logic [8:0] c;

        resetModel();
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_writeEn", writeEn, 1'b0);
        checkOutput("rst_writeMask", writeMask, 9'd0);
        checkOutput("rst_writePlayer", writePlayer, 1'b0);
        checkOutput("rst_clearBoard", clearBoard, 1'b0);
        checkOutput("rst_reject", reject, 1'b0);
        checkOutput("rst_turn", turn, 1'b0);
        checkOutput("rst_winner", winner, 2'b00);
        checkOutput("rst_winLine", winLine, 8'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_noClearAfter", clearBoard, 1'b0);

`ifdef TURN_TIMEOUT_EN
        wrSeen = 0;
        for (int e = 2; e <= 32; e++) begin
            @(posedge clk); #1;
            if (writeEn === 1'b1) wrSeen++;
            if (e == 15) checkOutput("to_beforeFirst", turn, 1'b0);
            if (e == 16) checkOutput("to_first", turn, 1'b1);
            if (e == 31) checkOutput("to_beforeSecond", turn, 1'b1);
            if (e == 32) checkOutput("to_second", turn, 1'b0);
        end
        checkOutput("to_noWrite", wrSeen, 0);
`else
        // Occupied-cell rejection using a board preloaded by the game model.
        preloadO   = 9'h001;
        refCell[0] = 2;
        applyStimulus(9'h001, "occupied");
        preloadO = 9'd0;
        doNewGame("ng0");

        // First move latency and X row win.
        applyStimulus(9'h001, "firstMove");
        applyStimulus(9'h003, "twoBits");
        applyStimulus(9'h000, "zeroBits");
        applyStimulus(9'h008, "oCell3");
        applyStimulus(9'h002, "xCell1");
        applyStimulus(9'h010, "oCell4");
        applyStimulus(9'h004, "xCell2");
        checkOutput("xWin_winLine01", winLine, 8'h01);
        applyStimulus(9'h100, "overIgnored");
        doNewGame("ng1");

        // Nine moves with no line completed.
        drawSeq = '{9'h001, 9'h002, 9'h004, 9'h010, 9'h008, 9'h020, 9'h080, 9'h040, 9'h100};
        for (int i = 0; i < 9; i++) applyStimulus(drawSeq[i], "draw");
        checkOutput("draw_winner", winner, 2'b11);
        applyStimulus(9'h001, "drawOver");
        doNewGame("ng2");

        // newGame during WRITE: write still completes, then CLEAR.
        cursor  = 9'h010;
        moveReq = 1'b1;
        @(posedge clk); #1;
        moveReq = 1'b0;
        @(posedge clk); #1;
        checkOutput("ngw_writeEn", writeEn, 1'b1);
        newGame = 1'b1;
        @(posedge clk); #1;
        newGame = 1'b0;
        checkOutput("ngw_clearOn", clearBoard, 1'b1);
        checkOutput("ngw_writeOff", writeEn, 1'b0);
        @(posedge clk); #1;
        checkOutput("ngw_clearOff", clearBoard, 1'b0);
        checkOutput("ngw_turn", turn, 1'b0);
        checkOutput("ngw_board", boardX | boardO, 9'd0);
        resetModel();

        // Random games.
        for (int g = 0; g < 6; g++) begin
            for (int m = 0; m < 20 && refWinner == 2'b00; m++) begin
                if ($urandom_range(4, 0) == 0) c = 9'($urandom);
                else c = 9'd1 << $urandom_range(8, 0);
                applyStimulus(c, "rand");
            end
            applyStimulus(9'd1 << $urandom_range(8, 0), "randEnd");
            doNewGame("ngRand");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
